// File: rtl/pu_riscv_verilog_pkg.sv
// Shared definitions for the RISC-V pipeline write-back stage.
//   - Default widths and reset PC
//   - Opcodes, load funct3 codes, exception cause bit indices, NOP encoding
//   - writes_rd(): does an opcode write the integer register file
package pu_riscv_verilog_pkg;

    localparam int          XLEN_DEF           = 64;
    localparam int          ILEN_DEF           = 64;
    localparam int          EXCEPTION_SIZE_DEF = 16;
    localparam logic [63:0] PC_INIT_DEF        = 64'h0000_0000_8000_0000;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;   // addi x0, x0, 0

    // Major opcodes
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_AMO      = 7'b0101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Bit positions inside the exception vector (RISC-V cause codes)
    localparam int EXC_LOAD_ADDR_MISALIGNED = 4;
    localparam int EXC_LOAD_ACCESS_FAULT    = 5;

    // Opcodes whose result lands in rd of the integer register file
    function automatic logic writes_rd(input logic [6:0] opcode);
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM32, OPC_AMO, OPC_OP,
            OPC_LUI, OPC_OP32, OPC_JALR, OPC_JAL, OPC_SYSTEM: writes_rd = 1'b1;
            default:                                           writes_rd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pu_riscv_wb_load_align.sv
// Load data alignment and extension (purely combinational).
//   dmem_q  : raw XLEN-wide word returned by the data bus
//   adr     : low three bits of the load address
//   funct3  : load type (LB/LH/LW/LD/LBU/LHU/LWU)
//   data    : right-justified, sign/zero-extended load result
// The byte offset is rounded down to the access size, so address bits below
// the access alignment never affect the result.
module pu_riscv_wb_load_align
    import pu_riscv_verilog_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] dmem_q,
    input  logic [2:0]      adr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [2:0]      offset;
    logic [XLEN-1:0] shifted;

    always_comb begin
        case (funct3[1:0])
            2'b00:   offset = adr;
            2'b01:   offset = {adr[2:1], 1'b0};
            2'b10:   offset = {adr[2], 2'b00};
            default: offset = 3'b000;
        endcase
        shifted = dmem_q >> {offset, 3'b000};

        case (funct3)
            F3_LB:   data = XLEN'($signed(shifted[7:0]));
            F3_LH:   data = XLEN'($signed(shifted[15:0]));
            F3_LW:   data = XLEN'($signed(shifted[31:0]));
            F3_LBU:  data = XLEN'(shifted[7:0]);
            F3_LHU:  data = XLEN'(shifted[15:0]);
            F3_LWU:  data = XLEN'(shifted[31:0]);
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/pu_riscv_wb.sv
// RISC-V write-back stage: retires the memory-stage instruction, waits for
// load data from the data bus, and produces the register-file write.
//   clk, rst                      : clock, asynchronous active-high reset
//   mem_*                         : instruction arriving from the memory stage
//   dmem_ack / dmem_err / dmem_q  : data-bus response for a pending load
//   wb_stall                      : combinational, holds the pipeline while a load waits
//   wb_*                          : registered retired-instruction information
//   rf_dst / rf_wdata / rf_we     : registered register-file write port
// Optional feature: define PU_RISCV_WB_MISALIGN_CHECK_EN to flag loads whose
// address is not aligned to the access size as LOAD_ADDR_MISALIGNED.
module pu_riscv_wb
    import pu_riscv_verilog_pkg::*;
#(
    parameter int               XLEN           = XLEN_DEF,
    parameter int               ILEN           = ILEN_DEF,
    parameter int               EXCEPTION_SIZE = EXCEPTION_SIZE_DEF,
    parameter logic [XLEN-1:0]  PC_INIT        = XLEN'(PC_INIT_DEF)
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [XLEN-1:0]           mem_pc,
    input  logic [ILEN-1:0]           mem_instr,
    input  logic                      mem_bubble,
    input  logic [EXCEPTION_SIZE-1:0] mem_exception,
    input  logic [XLEN-1:0]           mem_r,
    input  logic [XLEN-1:0]           mem_memadr,

    input  logic                      dmem_ack,
    input  logic                      dmem_err,
    input  logic [XLEN-1:0]           dmem_q,

    output logic                      wb_stall,
    output logic [XLEN-1:0]           wb_pc,
    output logic [ILEN-1:0]           wb_instr,
    output logic                      wb_bubble,
    output logic [EXCEPTION_SIZE-1:0] wb_exception,
    output logic [XLEN-1:0]           wb_badaddr,
    output logic [4:0]                rf_dst,
    output logic [XLEN-1:0]           rf_wdata,
    output logic                      rf_we
);

    typedef enum logic {RUN, WAIT} state_t;

    localparam logic [EXCEPTION_SIZE-1:0] EXC_FAULT_VEC =
        EXCEPTION_SIZE'(1) << EXC_LOAD_ACCESS_FAULT;
    localparam logic [EXCEPTION_SIZE-1:0] EXC_MISALIGN_VEC =
        EXCEPTION_SIZE'(1) << EXC_LOAD_ADDR_MISALIGNED;

    state_t          state;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            is_load;
    logic            misaligned;
    logic            load_mem;     // load that actually goes out to memory
    logic            stall;
    logic            rd_write;
    logic [XLEN-1:0] load_data;

    assign opcode  = mem_instr[6:0];
    assign rd      = mem_instr[11:7];
    assign funct3  = mem_instr[14:12];
    assign is_load = (opcode == OPC_LOAD) & ~mem_bubble & (mem_exception == '0);

`ifdef PU_RISCV_WB_MISALIGN_CHECK_EN
    always_comb begin
        case (funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = mem_memadr[0];
            2'b10:   misaligned = |mem_memadr[1:0];
            default: misaligned = |mem_memadr[2:0];
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    // A misaligned load (when checked) retires immediately as an exception.
    assign load_mem = is_load & ~misaligned;
    assign stall    = load_mem & ~dmem_ack & ~dmem_err;
    assign wb_stall = stall & ~rst;
    assign rd_write = writes_rd(opcode) & (rd != 5'd0);

    pu_riscv_wb_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .dmem_q (dmem_q),
        .adr    (mem_memadr[2:0]),
        .funct3 (funct3),
        .data   (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            wb_pc        <= PC_INIT;
            wb_instr     <= ILEN'(INSTR_NOP);
            wb_bubble    <= 1'b1;
            wb_exception <= '0;
            wb_badaddr   <= '0;
            rf_dst       <= '0;
            rf_wdata     <= '0;
            rf_we        <= 1'b0;
        end else begin
            case (state)
                RUN:     if (stall)               state <= WAIT;
                WAIT:    if (dmem_ack | dmem_err) state <= RUN;
                default:                          state <= RUN;
            endcase

            if (!stall) begin
                wb_pc      <= mem_pc;
                wb_instr   <= mem_instr;
                wb_bubble  <= mem_bubble;
                rf_dst     <= rd;
                rf_wdata   <= mem_r;
                wb_badaddr <= '0;

                if (mem_bubble) begin
                    wb_exception <= '0;
                    rf_we        <= 1'b0;
                end else if (mem_exception != '0) begin
                    wb_exception <= mem_exception;
                    wb_badaddr   <= mem_memadr;
                    rf_we        <= 1'b0;
                end else if (is_load && misaligned) begin
                    wb_exception <= EXC_MISALIGN_VEC;
                    wb_badaddr   <= mem_memadr;
                    rf_we        <= 1'b0;
                end else if (is_load && dmem_err) begin
                    // error beats a simultaneous ack
                    wb_exception <= mem_exception | EXC_FAULT_VEC;
                    wb_badaddr   <= mem_memadr;
                    rf_we        <= 1'b0;
                end else if (is_load) begin
                    wb_exception <= '0;
                    rf_wdata     <= load_data;
                    rf_we        <= rd_write;
                end else begin
                    wb_exception <= '0;
                    rf_we        <= rd_write;
                end
            end
        end
    end

    // The FSM only tracks bus progress; nothing downstream consumes it.
    logic unused_state;
    assign unused_state = (state == WAIT);

endmodule

// File: tb/tb_pu_riscv_wb.sv
module tb_pu_riscv_wb;

    localparam int EXC = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [63:0]    mem_pc, mem_instr, mem_r, mem_memadr;
    logic           mem_bubble;
    logic [EXC-1:0] mem_exception;
    logic           dmem_ack, dmem_err;
    logic [63:0]    dmem_q;
    logic           wb_stall, wb_bubble, rf_we;
    logic [63:0]    wb_pc, wb_instr, wb_badaddr, rf_wdata;
    logic [EXC-1:0] wb_exception;
    logic [4:0]     rf_dst;

    int tests_run    = 0;
    int tests_failed = 0;
    int txn_no       = 0;

    // last values the outputs must hold while stalled
    logic [63:0] prev_pc, prev_wdata;
    logic        prev_we;

    pu_riscv_wb dut (
        .clk           (clk),
        .rst           (rst),
        .mem_pc        (mem_pc),
        .mem_instr     (mem_instr),
        .mem_bubble    (mem_bubble),
        .mem_exception (mem_exception),
        .mem_r         (mem_r),
        .mem_memadr    (mem_memadr),
        .dmem_ack      (dmem_ack),
        .dmem_err      (dmem_err),
        .dmem_q        (dmem_q),
        .wb_stall      (wb_stall),
        .wb_pc         (wb_pc),
        .wb_instr      (wb_instr),
        .wb_bubble     (wb_bubble),
        .wb_exception  (wb_exception),
        .wb_badaddr    (wb_badaddr),
        .rf_dst        (rf_dst),
        .rf_wdata      (rf_wdata),
        .rf_we         (rf_we)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_writes_rd(input logic [6:0] opc);
        return opc inside {7'h03, 7'h13, 7'h17, 7'h1B, 7'h2F, 7'h33,
                           7'h37, 7'h3B, 7'h67, 7'h6F, 7'h73};
    endfunction

    // One instruction through write-back: 'delay' cycles without a bus
    // response (loads only), then ack, err, or both.
    task automatic do_txn(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                          input logic bub, input logic [EXC-1:0] exc, input logic [63:0] r,
                          input logic [63:0] adr, input logic [63:0] q,
                          input int delay, input bit err, input bit both);
        logic [63:0] instr, mask, v, e_wdata;
        logic [EXC-1:0] e_exc;
        bit is_load, mis, e_we;
        int nbytes, off_al, waits;

        instr = {$urandom, $urandom};
        instr[6:0]   = opc;
        instr[11:7]  = rd;
        instr[14:12] = f3;
        mem_pc = {$urandom, $urandom};
        mem_instr = instr;
        mem_bubble = bub;
        mem_exception = exc;
        mem_r = r;
        mem_memadr = adr;
        dmem_q = q;
        dmem_ack = 1'b0;
        dmem_err = 1'b0;

        is_load = (opc == 7'h03) && !bub && (exc == 0);
        nbytes  = 1 << f3[1:0];
`ifdef PU_RISCV_WB_MISALIGN_CHECK_EN
        mis = (adr % nbytes) != 0;
`else
        mis = 1'b0;
`endif
        waits = (is_load && !mis) ? delay : 0;

        for (int i = 0; i < waits; i++) begin
            #1;
            check_value("stall_wait", wb_stall, 1'b1);
            check_value("hold_pc", wb_pc, prev_pc);
            check_value("hold_we", rf_we, prev_we);
            step();
        end

        if (is_load && !mis) begin
            dmem_err = err;
            dmem_ack = err ? both : 1'b1;
        end else begin
            dmem_ack = $urandom_range(0, 1);
        end
        #1;
        check_value("stall_resp", wb_stall, 1'b0);
        step();

        // reference result
        e_exc = '0; e_we = 0; e_wdata = r;
        if (bub) begin
            e_exc = '0;
        end else if (exc != 0) begin
            e_exc = exc;
        end else if (is_load && mis) begin
            e_exc = EXC'(1) << 4;
        end else if (is_load && err) begin
            e_exc = EXC'(1) << 5;
        end else if (is_load) begin
            off_al = (adr % 8) - ((adr % 8) % nbytes);
            mask = (nbytes == 8) ? {64{1'b1}} : ((64'd1 << (8 * nbytes)) - 64'd1);
            v = (q >> (8 * off_al)) & mask;
            if (!f3[2] && nbytes < 8 && v[8 * nbytes - 1]) v = v | ~mask;
            e_wdata = v;
            e_we = (rd != 0);
        end else begin
            e_we = model_writes_rd(opc) && (rd != 0);
        end

        check_value("wb_pc", wb_pc, mem_pc);
        check_value("wb_instr", wb_instr, instr);
        check_value("wb_bubble", wb_bubble, bub);
        check_value("wb_exception", wb_exception, e_exc);
        check_value("rf_dst", rf_dst, rd);
        check_value("rf_we", rf_we, e_we);
        if (e_we) check_value("rf_wdata", rf_wdata, e_wdata);
        if (e_exc != 0) check_value("wb_badaddr", wb_badaddr, adr);

        prev_pc = wb_pc; prev_we = rf_we; prev_wdata = rf_wdata;
        txn_no++;
        $display("[TB] txn %0d opc=%02h f3=%0d rd=%0d bub=%0d exc=%h wait=%0d err=%0d we=%0d wdata=%h",
                 txn_no, opc, f3, rd, bub, exc, waits, err, rf_we, rf_wdata);
    endtask

    initial begin
        logic [6:0] alu_ops [12];
        int kind;
        logic [6:0] opc;
        logic [2:0] f3;

        alu_ops = '{7'h13, 7'h33, 7'h1B, 7'h3B, 7'h37, 7'h17, 7'h6F, 7'h67,
                    7'h73, 7'h2F, 7'h23, 7'h63};

        rst = 1'b1;
        mem_pc = '0; mem_instr = '0; mem_bubble = 1'b1; mem_exception = '0;
        mem_r = '0; mem_memadr = '0; dmem_ack = 1'b0; dmem_err = 1'b0; dmem_q = '0;
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_bubble", wb_bubble, 1'b1);
        check_value("rst_pc", wb_pc, 64'h8000_0000);
        check_value("rst_instr", wb_instr, 64'h13);
        check_value("rst_we", rf_we, 1'b0);
        check_value("rst_exc", wb_exception, '0);
        check_value("rst_stall", wb_stall, 1'b0);
        rst = 1'b0;
        prev_pc = wb_pc; prev_we = rf_we; prev_wdata = rf_wdata;

        // directed cases
        do_txn(7'h13, 3'd0, 5'd5, 0, '0, 64'h1234, 64'h0, 64'h0, 0, 0, 0);
        check_value("addi_wdata", rf_wdata, 64'h1234);
        do_txn(7'h13, 3'd0, 5'd0, 0, '0, 64'h1234, 64'h0, 64'h0, 0, 0, 0);
        do_txn(7'h03, 3'd0, 5'd7, 0, '0, 64'h0, 64'h0000_0000_0000_1003,
               64'h0000_0000_8000_0000, 3, 0, 0);
        check_value("lb_sext", rf_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        do_txn(7'h03, 3'd4, 5'd7, 0, '0, 64'h0, 64'h0000_0000_0000_1003,
               64'h0000_0000_8000_0000, 3, 0, 0);
        do_txn(7'h03, 3'd2, 5'd8, 0, '0, 64'h0, 64'h0000_0000_0000_2000, 64'hDEAD, 2, 1, 0);
        do_txn(7'h03, 3'd3, 5'd9, 0, '0, 64'h0, 64'h0000_0000_0000_3000,
               64'h0123_4567_89AB_CDEF, 0, 0, 0);
        do_txn(7'h03, 3'd2, 5'd10, 0, '0, 64'h0, 64'h0000_0000_0000_1002,
               64'h1122_3344_5566_7788, 0, 0, 0);
        do_txn(7'h03, 3'd1, 5'd11, 0, '0, 64'h0, 64'h0000_0000_0000_4004, 64'h55, 1, 1, 1);
        do_txn(7'h03, 3'd0, 5'd12, 0, 16'h0004, 64'h0, 64'h0000_0000_0000_5001, 64'h0, 0, 0, 0);
        do_txn(7'h03, 3'd0, 5'd12, 1, '0, 64'h0, 64'h0, 64'h0, 0, 0, 0);

        // reset in the middle of a load wait
        mem_instr = {32'h0, 17'h0, 3'd3, 5'd4, 7'h03};
        mem_bubble = 1'b0; mem_exception = '0; mem_memadr = 64'h6000;
        dmem_ack = 1'b0; dmem_err = 1'b0;
        #1;
        check_value("wait_stall0", wb_stall, 1'b1);
        step();
        check_value("wait_stall1", wb_stall, 1'b1);
        rst = 1'b1;
        #1;
        check_value("rst_wait_stall", wb_stall, 1'b0);
        check_value("rst_wait_pc", wb_pc, 64'h8000_0000);
        check_value("rst_wait_bubble", wb_bubble, 1'b1);
        mem_bubble = 1'b1;
        dmem_ack = 1'b1;
        rst = 1'b0;
        #1;
        check_value("late_ack_stall", wb_stall, 1'b0);
        step();
        check_value("late_ack_bubble", wb_bubble, 1'b1);
        check_value("late_ack_we", rf_we, 1'b0);
        prev_pc = wb_pc; prev_we = rf_we; prev_wdata = rf_wdata;

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 9);
            f3 = 3'($urandom_range(0, 6));
            case (kind)
                0: do_txn(($urandom_range(0, 1) != 0) ? 7'h03 : alu_ops[$urandom_range(0, 11)],
                          f3, 5'($urandom), 1, 16'($urandom), {$urandom, $urandom},
                          {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 0);
                1: do_txn(7'h03, f3, 5'($urandom), 0, 16'($urandom_range(1, 65535)),
                          {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 0);
                2, 3, 4, 5: do_txn(7'h03, f3, 5'($urandom), 0, '0, {$urandom, $urandom},
                          {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3), 0, 0);
                6: do_txn(7'h03, f3, 5'($urandom), 0, '0, {$urandom, $urandom},
                          {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3), 1,
                          $urandom_range(0, 1) != 0);
                default: begin
                    opc = alu_ops[$urandom_range(0, 11)];
                    do_txn(opc, f3, 5'($urandom), 0, '0, {$urandom, $urandom},
                           {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 0);
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
